apb_irq_dispatcher: RTL and testbench
=====================================

# apb_irq_dispatcher

Sequences interrupt delivery from the interrupt service unit's pending vector to a single core. It arbitrates among the enabled pending lines and presents one ID through a req/ack handshake. On acceptance it returns a one-hot clear pulse to the service unit, then holds the line in-service until software writes end-of-interrupt. It is an APB slave with its own control, mask, timeout, status and EOI registers, and sits beside the event unit on the same peripheral bus.

## Interface
- APB_ADDR_WIDTH, 12, APB address width.
- TIMEOUT_W, 16, width of the request timeout counter and register.
- HCLK  in  1  clock; all state changes on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address; only bits [4:2] decoded.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1 each  APB control.
- PRDATA  out  32  read data, combinational from the decoded register; 0 when not selected.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  1 during the access phase for an unmapped offset.
- irq_pending_i  in  32  level pending vector from the interrupt service unit.
- irq_req_o  out  1  interrupt request to core.
- irq_id_o  out  5  ID of the requested or in-service line.
- irq_ack_i  in  1  core accepts the current request.
- irq_clr_o  out  32  one-hot, one-cycle clear pulse to the service unit.

## Operation
- Registers are at offsets from base:
  - 0x00 CTRL: bit0 EN, bit1 RR (reserved 0 without the macro).
  - 0x04 MASK: 1 = line enabled.
  - 0x08 TIMEOUT: TIMEOUT_W bits; 0 disables the timeout.
  - 0x0C STATUS (RO): [1:0] state, [8:4] irq_id, [16] in-service.
  - 0x10 EOI (WO): any write.
- Unmapped offsets read 0 and set PSLVERR. Writes happen when PSEL & PENABLE & PWRITE.
- Reset values: CTRL=0, MASK=0, TIMEOUT=0, state IDLE, irq_req_o=0, irq_id_o=0, irq_clr_o=0, RR pointer=0.
- Candidates are irq_pending_i & MASK.
- Arbitration (fixed mode): the lowest-index candidate wins.
- FSM transitions:
  - IDLE→REQ when EN and candidates≠0. Latch the winner into irq_id_o, set irq_req_o, clear the timeout counter.
  - REQ→SERVICE when irq_ack_i=1. Drop irq_req_o. Pulse irq_clr_o[irq_id_o] for exactly one cycle.
  - REQ→IDLE (withdraw) when the latched line's candidate bit drops, EN=0, or the counter reaches TIMEOUT (TIMEOUT≠0). Drop irq_req_o.
  - SERVICE→IDLE on an EOI write.
- Priority within REQ: ack beats withdraw and timeout when they occur in the same cycle.
- EOI writes in IDLE or REQ are ignored.
- Clearing EN in SERVICE does not abort; the block waits for EOI, then stays IDLE.
- The timeout counter increments each cycle in REQ and saturates at all-ones.
- MASK or TIMEOUT writes take effect on the next cycle. They never alter a latched ID.

## Timing
- Pending rises in cycle N (EN=1, unmasked) → irq_req_o=1 and irq_id_o valid in N+1.
- ack sampled in cycle M → irq_req_o=0 and irq_clr_o pulse in M+1. STATUS shows SERVICE in M+1.
- EOI write access phase in cycle E → IDLE in E+1. The earliest new request is in E+2.
- Timeout with TIMEOUT=T: the request is asserted for exactly T cycles, then withdrawn. Re-arbitration can re-request at the earliest 2 cycles later.
- irq_id_o is stable whenever irq_req_o=1.
- HRESET asserted in any state → all outputs return to reset values on the next edge. No clear pulse is emitted.

## Configuration
- IRQ_DISPATCH_RR_EN defined: CTRL.RR is writable.
  - With RR=1, the search starts at a 5-bit pointer and wraps 31→0.
  - After each ack of ID k, the pointer becomes (k+1) mod 32.
  - With RR=0, arbitration is fixed priority.
- IRQ_DISPATCH_RR_EN undefined: fixed priority only. CTRL bit1 reads 0 and ignores writes. No pointer register exists.

## Test plan
- Fixed priority: MASK=0xFFFFFFFF, EN=1, pending=0x00000014 → irq_id_o=2 one cycle later. After ack, irq_clr_o=0x00000004 for one cycle. STATUS.state=SERVICE.
- Mask and EOI: MASK=0x00000010, pending=0x00000014, EN=1 → ID 4 requested. Ack, then EOI write → IDLE next cycle. With pending still set, ID 4 is re-requested.
- Timeout: TIMEOUT=5, no ack → irq_req_o high exactly 5 cycles, then withdrawn. Ack in the same cycle as count==5 → SERVICE and clear pulse.
- Withdraw: the requested line's pending drops while in REQ → irq_req_o=0 next cycle, no clear pulse. EOI write in IDLE has no effect.
- Round-robin (macro defined, RR=1, all masked in, pending=0x80000003):
  - Grants are 0, then 1, then 31, then 0.
  - The pointer wraps 31→0.
- Reset mid-SERVICE: HRESET for one cycle → irq_req_o=0, irq_id_o=0, CTRL/MASK=0, STATUS=IDLE.

Source files
------------

// File: rtl/apb_irq_dispatcher_if.sv
// Bundles the APB slave port and the core interrupt handshake of the dispatcher.
// Latency: none, wires only.
// Backpressure: none here; PREADY and the req/ack pair are carried unchanged.
interface apb_irq_dispatcher_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;
    logic [31:0]               irq_pending_i;
    logic                      irq_req_o;
    logic [4:0]                irq_id_o;
    logic                      irq_ack_i;
    logic [31:0]               irq_clr_o;

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, irq_pending_i, irq_ack_i,
        output PRDATA, PREADY, PSLVERR, irq_req_o, irq_id_o, irq_clr_o
    );

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE, irq_pending_i, irq_ack_i,
        input  PRDATA, PREADY, PSLVERR, irq_req_o, irq_id_o, irq_clr_o
    );
endinterface

// File: rtl/apb_irq_dispatcher.sv
// Arbitrates enabled pending interrupt lines, requests one ID from the core, clears it on ack, holds it until EOI.
// Latency: pending->request 1 cycle, ack->clear pulse 1 cycle, EOI->idle 1 cycle; APB has zero wait states.
// Backpressure: a request is held until ack, withdrawal or timeout; IRQ_DISPATCH_RR_EN adds round-robin arbitration.
module apb_irq_dispatcher #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_W      = 16
) (
    input logic                 HCLK,
    input logic                 HRESET,
    apb_irq_dispatcher_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;
    logic                 ctrl_en;
    logic                 rr_bit;
    logic [31:0]          mask;
    logic [TIMEOUT_W-1:0] timeout;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [4:0]           id;
    logic [31:0]          clr;
    logic [31:0]          cand;
    logic [4:0]           winner;
    logic                 id_load;
    logic                 clr_fire;
    logic                 timeout_hit;
    logic [2:0]           offset;
    logic                 wr;
    logic                 eoi_wr;
    logic                 mapped;
    logic [31:0]          rdata;
    logic                 unused_addr;

    // Lowest set bit index of a vector; 0 when the vector is empty.
    function automatic logic [4:0] lowest(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = i[4:0];
        end
        return r;
    endfunction

    assign offset      = bus.PADDR[4:2];
    assign unused_addr = ^{bus.PADDR[APB_ADDR_WIDTH-1:5], bus.PADDR[1:0]};
    assign wr          = bus.PSEL & bus.PENABLE & bus.PWRITE;
    assign eoi_wr      = wr & (offset == 3'd4);
    assign mapped      = (offset <= 3'd4);
    assign cand        = bus.irq_pending_i & mask;

    // Saturating count; the request is withdrawn in the cycle the count would reach TIMEOUT.
    assign cnt_inc     = (cnt == {TIMEOUT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign timeout_hit = (timeout != '0) && (cnt_inc >= timeout);

`ifdef IRQ_DISPATCH_RR_EN
    logic        ctrl_rr;
    logic [4:0]  ptr;
    logic [31:0] rot;

    // Rotating the candidates by the pointer turns the round-robin search into a lowest-index search.
    assign rot    = 32'({cand, cand} >> ptr);
    assign winner = ctrl_rr ? (lowest(rot) + ptr) : lowest(cand);
    assign rr_bit = ctrl_rr;

    // Round-robin pointer moves past the line the core just accepted.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ptr <= '0;
        end else if (clr_fire) begin
            ptr <= id + 5'd1;
        end
    end
`else
    assign winner = lowest(cand);
    assign rr_bit = 1'b0;
`endif

    // Software-visible configuration registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_en <= 1'b0;
            mask    <= '0;
            timeout <= '0;
`ifdef IRQ_DISPATCH_RR_EN
            ctrl_rr <= 1'b0;
`endif
        end else if (wr) begin
            case (offset)
                3'd0: begin
                    ctrl_en <= bus.PWDATA[0];
`ifdef IRQ_DISPATCH_RR_EN
                    ctrl_rr <= bus.PWDATA[1];
`endif
                end
                3'd1:    mask    <= bus.PWDATA;
                3'd2:    timeout <= bus.PWDATA[TIMEOUT_W-1:0];
                default: ;
            endcase
        end
    end

    // Next-state decode; ack has priority over every withdrawal cause.
    always_comb begin
        state_n  = state;
        id_load  = 1'b0;
        clr_fire = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en && (cand != '0)) begin
                    state_n = REQ;
                    id_load = 1'b1;
                end
            end
            REQ: begin
                if (bus.irq_ack_i) begin
                    state_n  = SERVICE;
                    clr_fire = 1'b1;
                end else if (!cand[id] || !ctrl_en || timeout_hit) begin
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_wr) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, latched ID, request timer and the one-cycle clear pulse.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
            id    <= '0;
            cnt   <= '0;
            clr   <= '0;
        end else begin
            state <= state_n;
            clr   <= clr_fire ? (32'd1 << id) : '0;
            if (id_load) begin
                id  <= winner;
                cnt <= '0;
            end else if (state == REQ) begin
                cnt <= cnt_inc;
            end
        end
    end

    // APB read mux; STATUS is read-only and EOI reads as zero.
    always_comb begin
        rdata = '0;
        if (bus.PSEL) begin
            case (offset)
                3'd0:    rdata = {30'd0, rr_bit, ctrl_en};
                3'd1:    rdata = mask;
                3'd2:    rdata = 32'(timeout);
                3'd3:    rdata = {15'd0, (state == SERVICE), 7'd0, id, 2'd0, state};
                default: rdata = '0;
            endcase
        end
    end

    assign bus.PRDATA    = rdata;
    assign bus.PREADY    = 1'b1;
    assign bus.PSLVERR   = bus.PSEL & bus.PENABLE & ~mapped;
    assign bus.irq_req_o = (state == REQ);
    assign bus.irq_id_o  = id;
    assign bus.irq_clr_o = clr;

endmodule

// File: tb/tb_apb_irq_dispatcher.sv
// Directed bench for apb_irq_dispatcher: register vector table plus handshake sequences.
// Latency: checks pending->req, ack->clear and EOI->idle cycle timing.
// Backpressure: exercises ack, withdrawal, timeout and EOI ordering.
module tb_apb_irq_dispatcher;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    apb_irq_dispatcher_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_irq_dispatcher #(.APB_ADDR_WIDTH(12), .TIMEOUT_W(16)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

`ifdef IRQ_DISPATCH_RR_EN
    localparam logic [31:0] CTRL_RB = 32'h3;
`else
    localparam logic [31:0] CTRL_RB = 32'h1;
`endif

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[21];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        bus.PADDR   = a;
        bus.PWDATA  = d;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        #1;
        err = bus.PSLVERR;
        step();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        bus.PADDR   = a;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        #1;
        d   = bus.PRDATA;
        err = bus.PSLVERR;
        step();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] m,
                            input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        check(name, d & m, exp);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!bus.irq_req_o && n < 20) begin
            step();
            n++;
        end
        check(name, 32'(bus.irq_req_o), 32'h1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          hi;

        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        bus.PADDR         = '0;
        bus.PWDATA        = '0;
        bus.PWRITE        = 1'b0;
        bus.PSEL          = 1'b0;
        bus.PENABLE       = 1'b0;
        bus.irq_pending_i = '0;
        bus.irq_ack_i     = 1'b0;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 12'h008, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 12'h00C, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b0, 12'h010, 32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 12'h004, 32'hA5A50F0F, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 12'h004, 32'h0,        32'hA5A50F0F, 1'b0};
        vecs[7]  = '{1'b1, 12'h008, 32'h00012345, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 12'h008, 32'h0,        32'h00002345, 1'b0};
        vecs[9]  = '{1'b1, 12'h000, 32'h00000003, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 12'h000, 32'h0,        CTRL_RB,      1'b0};
        vecs[11] = '{1'b0, 12'h014, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b0, 12'h01C, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b1, 12'h018, 32'h12345678, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 12'h00C, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 12'h00C, 32'h0,        32'h0,        1'b0};
        vecs[16] = '{1'b0, 12'h044, 32'h0,        32'hA5A50F0F, 1'b0};
        vecs[17] = '{1'b1, 12'h000, 32'h0,        32'h0,        1'b0};
        vecs[18] = '{1'b1, 12'h004, 32'h0,        32'h0,        1'b0};
        vecs[19] = '{1'b1, 12'h008, 32'h0,        32'h0,        1'b0};
        vecs[20] = '{1'b0, 12'h004, 32'h0,        32'h0,        1'b0};

        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_req", 32'(bus.irq_req_o), 32'h0);
        check("rst_id", 32'(bus.irq_id_o), 32'h0);
        check("rst_clr", bus.irq_clr_o, 32'h0);
        check("rst_pready", 32'(bus.PREADY), 32'h1);
        check("rst_prdata_unsel", bus.PRDATA, 32'h0);

        // Register vector table
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
                check($sformatf("regvec%0d_err", i), 32'(e), 32'(vecs[i].err));
            end else begin
                apb_read(vecs[i].addr, d, e);
                check($sformatf("regvec%0d_data", i), d, vecs[i].exp);
                check($sformatf("regvec%0d_err", i), 32'(e), 32'(vecs[i].err));
            end
        end

        // Fixed priority, ack, clear pulse, EOI, EOI ignored in REQ, withdraw
        wr(12'h004, 32'hFFFFFFFF);
        wr(12'h000, 32'h1);
        bus.irq_pending_i = 32'h00000014;
        step();
        check("fp_req", 32'(bus.irq_req_o), 32'h1);
        check("fp_id", 32'(bus.irq_id_o), 32'd2);
        check("fp_clr_before_ack", bus.irq_clr_o, 32'h0);
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        check("fp_req_after_ack", 32'(bus.irq_req_o), 32'h0);
        check("fp_clr_pulse", bus.irq_clr_o, 32'h00000004);
        step();
        check("fp_clr_one_cycle", bus.irq_clr_o, 32'h0);
        rd_check("fp_status", 12'h00C, 32'hFFFFFFFF, 32'h00010022);
        wr(12'h010, 32'h0);
        check("fp_eoi_idle", 32'(bus.irq_req_o), 32'h0);
        step();
        check("fp_rereq", 32'(bus.irq_req_o), 32'h1);
        wr(12'h010, 32'h0);
        check("eoi_in_req_ignored", 32'(bus.irq_req_o), 32'h1);
        bus.irq_pending_i = 32'h0;
        step();
        check("wd_req", 32'(bus.irq_req_o), 32'h0);
        check("wd_no_clr", bus.irq_clr_o, 32'h0);
        rd_check("wd_status_idle", 12'h00C, 32'h00010003, 32'h0);

        // Mask selects ID 4; EOI then re-request
        wr(12'h004, 32'h00000010);
        bus.irq_pending_i = 32'h00000014;
        step();
        check("mask_req", 32'(bus.irq_req_o), 32'h1);
        check("mask_id", 32'(bus.irq_id_o), 32'd4);
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        check("mask_clr", bus.irq_clr_o, 32'h00000010);
        wr(12'h010, 32'h0);
        check("mask_eoi_idle", 32'(bus.irq_req_o), 32'h0);
        step();
        check("mask_rereq", 32'(bus.irq_req_o), 32'h1);
        check("mask_rereq_id", 32'(bus.irq_id_o), 32'd4);
        bus.irq_pending_i = 32'h0;
        step();
        check("mask_wd", 32'(bus.irq_req_o), 32'h0);

        // Timeout of 5 cycles, re-request, then ack colliding with timeout
        wr(12'h004, 32'hFFFFFFFF);
        wr(12'h008, 32'd5);
        bus.irq_pending_i = 32'h00000001;
        step();
        hi = 0;
        while (bus.irq_req_o && hi < 30) begin
            hi++;
            step();
        end
        check("to_high_cycles", 32'(hi), 32'd5);
        check("to_no_clr", bus.irq_clr_o, 32'h0);
        step();
        check("to_rereq", 32'(bus.irq_req_o), 32'h1);
        repeat (4) step();
        check("to_still_req_c5", 32'(bus.irq_req_o), 32'h1);
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        check("to_ack_wins_req", 32'(bus.irq_req_o), 32'h0);
        check("to_ack_wins_clr", bus.irq_clr_o, 32'h00000001);
        rd_check("to_status_service", 12'h00C, 32'h00010003, 32'h00010002);
        bus.irq_pending_i = 32'h0;
        wr(12'h010, 32'h0);
        wr(12'h008, 32'h0);

        // EOI while idle has no effect
        wr(12'h010, 32'h0);
        rd_check("eoi_idle_status", 12'h00C, 32'h00010003, 32'h0);
        check("eoi_idle_req", 32'(bus.irq_req_o), 32'h0);

        // Reset in the middle of service
        bus.irq_pending_i = 32'h00000008;
        step();
        check("rs_id", 32'(bus.irq_id_o), 32'd3);
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        check("rs_clr", bus.irq_clr_o, 32'h00000008);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_req", 32'(bus.irq_req_o), 32'h0);
        check("rs_id0", 32'(bus.irq_id_o), 32'h0);
        check("rs_clr0", bus.irq_clr_o, 32'h0);
        rd_check("rs_ctrl", 12'h000, 32'hFFFFFFFF, 32'h0);
        rd_check("rs_mask", 12'h004, 32'hFFFFFFFF, 32'h0);
        rd_check("rs_status", 12'h00C, 32'hFFFFFFFF, 32'h0);
        bus.irq_pending_i = 32'h0;

`ifdef IRQ_DISPATCH_RR_EN
        // Round-robin grants 0, 1, 31, 0 with pointer wrap
        begin
            logic [4:0] exp_ids [4];
            logic [4:0] k;
            exp_ids[0] = 5'd0;
            exp_ids[1] = 5'd1;
            exp_ids[2] = 5'd31;
            exp_ids[3] = 5'd0;
            wr(12'h004, 32'hFFFFFFFF);
            wr(12'h000, 32'h3);
            bus.irq_pending_i = 32'h80000003;
            for (int g = 0; g < 4; g++) begin
                k = exp_ids[g];
                wait_req($sformatf("rr%0d_req", g));
                check($sformatf("rr%0d_id", g), 32'(bus.irq_id_o), 32'(k));
                bus.irq_ack_i = 1'b1;
                step();
                bus.irq_ack_i = 1'b0;
                check($sformatf("rr%0d_clr", g), bus.irq_clr_o, 32'h1 << k);
                wr(12'h010, 32'h0);
            end
            bus.irq_pending_i = 32'h0;
            step();
        end
`else
        // Fixed priority only: lowest line wins on every round
        wr(12'h004, 32'hFFFFFFFF);
        wr(12'h000, 32'h3);
        bus.irq_pending_i = 32'h80000003;
        for (int g = 0; g < 2; g++) begin
            wait_req($sformatf("fx%0d_req", g));
            check($sformatf("fx%0d_id", g), 32'(bus.irq_id_o), 32'd0);
            bus.irq_ack_i = 1'b1;
            step();
            bus.irq_ack_i = 1'b0;
            check($sformatf("fx%0d_clr", g), bus.irq_clr_o, 32'h1);
            wr(12'h010, 32'h0);
        end
        bus.irq_pending_i = 32'h0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
